// File: rtl/vend_controller.sv
// Vending sequencer: latches a product code, accumulates coin credit up to the
// price, pulses dispense once and pays back change/refund one unit per cycle.
module vend_controller #(
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 15,
  parameter int MOEDA_A     = 1,
  parameter int MOEDA_B     = 2,
  parameter int MOEDA_C     = 5,
  parameter int PRECO_REFRI = 3,
  parameter int PRECO_SAL   = 2,
  parameter int PRECO_SUCO  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          sel,
  input  logic                sel_valid,
  input  logic                moeda_a,
  input  logic                moeda_b,
  input  logic                moeda_c,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] saldo,
  output logic [3:0]          produto,
  output logic                dispense,
  output logic                troco,
  output logic                coin_reject,
  output logic                sel_err,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, COLLECT, DISPENSE, CHANGE, REFUND} state_t;

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [3:0]          COD_REFRI = 4'b1111;
  localparam logic [3:0]          COD_SAL   = 4'b1110;
  localparam logic [3:0]          COD_SUCO  = 4'b1100;
  localparam logic [SUM_W-1:0]    VAL_A     = SUM_W'(MOEDA_A);
  localparam logic [SUM_W-1:0]    VAL_B     = SUM_W'(MOEDA_B);
  localparam logic [SUM_W-1:0]    VAL_C     = SUM_W'(MOEDA_C);
  localparam logic [SUM_W-1:0]    MAX_S     = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] UM        = CREDIT_W'(1);

  function automatic logic [CREDIT_W-1:0] preco_de(input logic [3:0] c);
    case (c)
      COD_REFRI: return CREDIT_W'(PRECO_REFRI);
      COD_SAL:   return CREDIT_W'(PRECO_SAL);
      COD_SUCO:  return CREDIT_W'(PRECO_SUCO);
      default:   return '0;
    endcase
  endfunction

  function automatic logic codigo_valido(input logic [3:0] c);
    return (c == COD_REFRI) || (c == COD_SAL) || (c == COD_SUCO);
  endfunction

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] preco, preco_nx, saldo_nx;
  logic [3:0]          produto_nx;
  logic                dispense_nx, troco_nx, coin_reject_nx, sel_err_nx;
  logic                coin_any, coin_multi;
  logic [SUM_W-1:0]    coin_val, soma;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      saldo       <= '0;
      produto     <= '0;
      preco       <= '0;
      dispense    <= 1'b0;
      troco       <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      saldo       <= saldo_nx;
      produto     <= produto_nx;
      preco       <= preco_nx;
      dispense    <= dispense_nx;
      troco       <= troco_nx;
      coin_reject <= coin_reject_nx;
      sel_err     <= sel_err_nx;
      busy        <= (state_nx != IDLE);
    end
  end

  // The sum is one bit wider than saldo so an overflowing coin is detected, not wrapped.
  always_comb begin
    coin_any   = moeda_a | moeda_b | moeda_c;
    coin_multi = (moeda_a & moeda_b) | (moeda_a & moeda_c) | (moeda_b & moeda_c);
    coin_val   = '0;
    if (moeda_a)      coin_val = VAL_A;
    else if (moeda_b) coin_val = VAL_B;
    else if (moeda_c) coin_val = VAL_C;
    soma = {1'b0, saldo} + coin_val;
  end

  always_comb begin
    state_nx       = state;
    saldo_nx       = saldo;
    produto_nx     = produto;
    preco_nx       = preco;
    dispense_nx    = 1'b0;
    troco_nx       = 1'b0;
    coin_reject_nx = 1'b0;
    sel_err_nx     = 1'b0;
    unique case (state)
      IDLE: begin
        coin_reject_nx = coin_any;
        if (sel_valid) begin
          if (codigo_valido(sel)) begin
            produto_nx = sel;
            preco_nx   = preco_de(sel);
            state_nx   = COLLECT;
          end else begin
            sel_err_nx = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          coin_reject_nx = coin_any;
          state_nx       = REFUND;
        end else if (coin_any) begin
          if (coin_multi || (soma > MAX_S)) begin
            coin_reject_nx = 1'b1;
          end else begin
            saldo_nx = soma[CREDIT_W-1:0];
            if (soma >= {1'b0, preco}) state_nx = DISPENSE;
          end
        end
      end
      DISPENSE: begin
        coin_reject_nx = coin_any;
        dispense_nx    = 1'b1;
        saldo_nx       = saldo - preco;
        if (saldo == preco) begin
          produto_nx = '0;
          state_nx   = IDLE;
        end else begin
          state_nx = CHANGE;
        end
      end
      CHANGE, REFUND: begin
        coin_reject_nx = coin_any;
        if (saldo == '0) begin
          produto_nx = '0;
          state_nx   = IDLE;
        end else begin
          troco_nx = 1'b1;
          saldo_nx = saldo - UM;
          if (saldo == UM) begin
            produto_nx = '0;
            state_nx   = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: default instance plus a MAX_CREDIT=5 /
// PRECO_SUCO=5 instance for the overflow scenario.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sel = '0;
  logic       sel_valid = 1'b0, moeda_a = 1'b0, moeda_b = 1'b0, moeda_c = 1'b0, cancel = 1'b0;

  logic [3:0] saldo, produto;
  logic       dispense, troco, coin_reject, sel_err, busy;
  logic [3:0] saldo5, produto5;
  logic       dispense5, troco5, coin_reject5, sel_err5, busy5;

  int checks = 0;
  int errors = 0;

  vend_controller dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .sel_valid(sel_valid),
    .moeda_a(moeda_a), .moeda_b(moeda_b), .moeda_c(moeda_c), .cancel(cancel),
    .saldo(saldo), .produto(produto), .dispense(dispense), .troco(troco),
    .coin_reject(coin_reject), .sel_err(sel_err), .busy(busy)
  );

  vend_controller #(.MAX_CREDIT(5), .PRECO_SUCO(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .sel_valid(sel_valid),
    .moeda_a(moeda_a), .moeda_b(moeda_b), .moeda_c(moeda_c), .cancel(cancel),
    .saldo(saldo5), .produto(produto5), .dispense(dispense5), .troco(troco5),
    .coin_reject(coin_reject5), .sel_err(sel_err5), .busy(busy5)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    sel_valid = 1'b0; moeda_a = 1'b0; moeda_b = 1'b0; moeda_c = 1'b0; cancel = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; moeda_a = 1'b1; sel = 4'b1111; sel_valid = 1'b1;
    step();
    step();
    checks++; if (saldo !== 4'd0) begin errors++; $display("FAIL reset_saldo got %0d exp 0", saldo); end
    checks++; if (produto !== 4'b0000) begin errors++; $display("FAIL reset_produto got %b exp 0000", produto); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({dispense, troco, coin_reject, sel_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got %b exp 0000", {dispense, troco, coin_reject, sel_err}); end
    checks++; if (saldo5 !== 4'd0) begin errors++; $display("FAIL reset_saldo5 got %0d exp 0", saldo5); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_buy();
    sel = 4'b1111; sel_valid = 1'b1; step();
    checks++; if (busy !== 1'b1 || produto !== 4'b1111) begin
      errors++; $display("FAIL buy_select got busy=%b produto=%b exp 1 1111", busy, produto); end
    moeda_b = 1'b1; step();
    checks++; if (saldo !== 4'd2 || coin_reject !== 1'b0) begin
      errors++; $display("FAIL buy_coin1 got saldo=%0d rej=%b exp 2 0", saldo, coin_reject); end
    moeda_b = 1'b1; step();
    checks++; if (saldo !== 4'd4 || dispense !== 1'b0) begin
      errors++; $display("FAIL buy_coin2 got saldo=%0d disp=%b exp 4 0", saldo, dispense); end
    step();
    checks++; if (dispense !== 1'b1 || produto !== 4'b1111 || saldo !== 4'd1) begin
      errors++; $display("FAIL buy_dispense got disp=%b produto=%b saldo=%0d exp 1 1111 1", dispense, produto, saldo); end
    step();
    checks++; if (troco !== 1'b1 || dispense !== 1'b0 || saldo !== 4'd0) begin
      errors++; $display("FAIL buy_change got troco=%b disp=%b saldo=%0d exp 1 0 0", troco, dispense, saldo); end
    checks++; if (busy !== 1'b0 || produto !== 4'b0000) begin
      errors++; $display("FAIL buy_idle got busy=%b produto=%b exp 0 0000", busy, produto); end
    step();
    checks++; if (troco !== 1'b0) begin errors++; $display("FAIL buy_troco_end got %b exp 0", troco); end
  endtask

  task automatic test_cancel();
    int n_troco = 0;
    int n_disp = 0;
    sel = 4'b1100; sel_valid = 1'b1; step();
    moeda_a = 1'b1; step();
    checks++; if (saldo !== 4'd1) begin errors++; $display("FAIL cancel_coin got saldo=%0d exp 1", saldo); end
    cancel = 1'b1; moeda_b = 1'b1; step();
    checks++; if (coin_reject !== 1'b1 || saldo !== 4'd1) begin
      errors++; $display("FAIL cancel_wins got rej=%b saldo=%0d exp 1 1", coin_reject, saldo); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (troco === 1'b1) n_troco++;
      if (dispense === 1'b1) n_disp++;
    end
    checks++; if (n_troco !== 1) begin errors++; $display("FAIL cancel_troco_count got %0d exp 1", n_troco); end
    checks++; if (n_disp !== 0) begin errors++; $display("FAIL cancel_no_dispense got %0d exp 0", n_disp); end
    checks++; if (saldo !== 4'd0 || busy !== 1'b0 || produto !== 4'b0000) begin
      errors++; $display("FAIL cancel_idle got saldo=%0d busy=%b produto=%b exp 0 0 0000", saldo, busy, produto); end
  endtask

  task automatic test_errors();
    int n_troco = 0;
    sel = 4'b1010; sel_valid = 1'b1; step();
    checks++; if (sel_err !== 1'b1 || busy !== 1'b0 || produto !== 4'b0000) begin
      errors++; $display("FAIL err_selerr got err=%b busy=%b produto=%b exp 1 0 0000", sel_err, busy, produto); end
    moeda_a = 1'b1; cancel = 1'b1; step();
    checks++; if (sel_err !== 1'b0 || coin_reject !== 1'b1 || saldo !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_idle_coin got err=%b rej=%b saldo=%0d busy=%b exp 0 1 0 0", sel_err, coin_reject, saldo, busy); end
    sel = 4'b1110; sel_valid = 1'b1; step();
    moeda_a = 1'b1; moeda_b = 1'b1; step();
    checks++; if (coin_reject !== 1'b1 || saldo !== 4'd0) begin
      errors++; $display("FAIL err_multi_coin got rej=%b saldo=%0d exp 1 0", coin_reject, saldo); end
    sel = 4'b1111; sel_valid = 1'b1; moeda_c = 1'b1; step();
    checks++; if (coin_reject !== 1'b0 || saldo !== 4'd5 || produto !== 4'b1110) begin
      errors++; $display("FAIL err_reselect got rej=%b saldo=%0d produto=%b exp 0 5 1110", coin_reject, saldo, produto); end
    step();
    checks++; if (dispense !== 1'b1 || saldo !== 4'd3) begin
      errors++; $display("FAIL err_dispense got disp=%b saldo=%0d exp 1 3", dispense, saldo); end
    moeda_a = 1'b1; step();
    if (troco === 1'b1) n_troco++;
    checks++; if (coin_reject !== 1'b1 || saldo !== 4'd2) begin
      errors++; $display("FAIL err_change_coin got rej=%b saldo=%0d exp 1 2", coin_reject, saldo); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (troco === 1'b1) n_troco++;
    end
    checks++; if (n_troco !== 3 || saldo !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_change_done got troco=%0d saldo=%0d busy=%b exp 3 0 0", n_troco, saldo, busy); end
  endtask

  task automatic test_overflow();
    int n_troco = 0;
    pulse_reset();
    sel = 4'b1100; sel_valid = 1'b1; step();
    moeda_b = 1'b1; step();
    moeda_b = 1'b1; step();
    checks++; if (saldo5 !== 4'd4) begin errors++; $display("FAIL ovf_pre got saldo=%0d exp 4", saldo5); end
    moeda_c = 1'b1; step();
    checks++; if (coin_reject5 !== 1'b1 || saldo5 !== 4'd4) begin
      errors++; $display("FAIL ovf_reject got rej=%b saldo=%0d exp 1 4", coin_reject5, saldo5); end
    moeda_a = 1'b1; step();
    checks++; if (saldo5 !== 4'd5 || coin_reject5 !== 1'b0) begin
      errors++; $display("FAIL ovf_fill got saldo=%0d rej=%b exp 5 0", saldo5, coin_reject5); end
    step();
    checks++; if (dispense5 !== 1'b1 || saldo5 !== 4'd0 || produto5 !== 4'b0000 || busy5 !== 1'b0) begin
      errors++; $display("FAIL ovf_dispense got disp=%b saldo=%0d produto=%b busy=%b exp 1 0 0000 0",
                         dispense5, saldo5, produto5, busy5); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (troco5 === 1'b1) n_troco++;
    end
    checks++; if (n_troco !== 0) begin errors++; $display("FAIL ovf_no_troco got %0d exp 0", n_troco); end
  endtask

  task automatic test_midop_reset();
    pulse_reset();
    sel = 4'b1111; sel_valid = 1'b1; step();
    moeda_c = 1'b1; step();
    step();
    checks++; if (dispense !== 1'b1 || saldo !== 4'd2) begin
      errors++; $display("FAIL mid_dispense got disp=%b saldo=%0d exp 1 2", dispense, saldo); end
    rst_n = 1'b0; step();
    checks++; if (saldo !== 4'd0 || troco !== 1'b0 || produto !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got saldo=%0d troco=%b produto=%b busy=%b exp 0 0 0000 0",
                         saldo, troco, produto, busy); end
    rst_n = 1'b1; step();
    checks++; if (troco !== 1'b0 || saldo !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_after got troco=%b saldo=%0d busy=%b exp 0 0 0", troco, saldo, busy); end
  endtask

  initial begin
    test_reset();
    test_buy();
    test_cancel();
    test_errors();
    test_overflow();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
